// File: rtl/rr_mux_stage.sv
// ---------------------------------------------------------------------------
// rr_mux_stage
//
// Purpose:
//   N-input, WIDTH-bit multiplexer with a valid/ready handshake on every input
//   channel and a registered one-entry output stage. The grant comes from one
//   of two sources:
//     mode = 0 : round-robin arbitration across all input channels
//     mode = 1 : fixed selection by the sel index (legacy mux behaviour)
//   It sits between datapath producers (register file, ALU result paths) and
//   a single downstream consumer. The output stage can drain and reload in
//   the same cycle, so it sustains one word per cycle.
//
// Parameters:
//   WIDTH   data width per channel in bits
//   NUM_IN  number of input channels (2..16)
//   SEL_W   width of the channel index
//
// Ports:
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   mode       0 = round-robin, 1 = fixed select
//   sel        channel index used when mode = 1
//   in_data    packed channel data, channel i at [i*WIDTH +: WIDTH]
//   in_valid   per-channel valid
//   in_ready   per-channel ready (combinational, all zero during reset)
//   out_data   registered output data
//   out_sel    index of the channel that produced out_data
//   out_valid  output register holds a word
//   out_ready  consumer accepts the held word this cycle
//   xfer_cnt   count of words drained from the output register
//
// Configuration:
//   RR_MUX_STAT_EN  when defined, xfer_cnt is a saturating 32-bit counter of
//                   output drains. When undefined, xfer_cnt is tied to zero
//                   and no counter is built. The port list is the same in
//                   both builds.
// ---------------------------------------------------------------------------
module rr_mux_stage #(
    parameter int WIDTH  = 32,
    parameter int NUM_IN = 4,
    parameter int SEL_W  = $clog2(NUM_IN)
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    mode,
    input  logic [SEL_W-1:0]        sel,
    input  logic [NUM_IN*WIDTH-1:0] in_data,
    input  logic [NUM_IN-1:0]       in_valid,
    output logic [NUM_IN-1:0]       in_ready,
    output logic [WIDTH-1:0]        out_data,
    output logic [SEL_W-1:0]        out_sel,
    output logic                    out_valid,
    input  logic                    out_ready,
    output logic [31:0]             xfer_cnt
);

    // Output register and round-robin pointer state
    logic [WIDTH-1:0]  out_data_q,  out_data_d;
    logic [SEL_W-1:0]  out_sel_q,   out_sel_d;
    logic              out_valid_q, out_valid_d;
    logic [SEL_W-1:0]  ptr_q,       ptr_d;

    // Arbitration results for the current cycle
    logic [NUM_IN-1:0] grant;
    logic              rr_found;
    logic [SEL_W-1:0]  grant_idx;
    logic [WIDTH-1:0]  grant_data;
    logic              load_en;
    logic              xfer;

    // The output register can accept a new word when it is empty or when
    // the held word leaves this very cycle.
    assign load_en = !out_valid_q || out_ready;

    // Grant selection. Round-robin scans upward from ptr to the top channel,
    // then wraps and scans from channel 0 up to ptr-1; the first valid channel
    // found wins. Splitting the scan into two passes handles any NUM_IN,
    // including non-power-of-two counts, without modulo arithmetic.
    // Fixed mode only ever looks at the channel named by sel, so an
    // out-of-range sel simply matches no channel and grants nothing.
    always_comb begin
        grant    = '0;
        rr_found = 1'b0;
        if (mode) begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (sel == SEL_W'(i)) begin
                    grant[i] = in_valid[i];
                end
            end
        end else begin
            for (int i = 0; i < NUM_IN; i++) begin
                if (!rr_found && (i >= int'(ptr_q)) && in_valid[i]) begin
                    grant[i] = 1'b1;
                    rr_found = 1'b1;
                end
            end
            for (int i = 0; i < NUM_IN; i++) begin
                if (!rr_found && (i < int'(ptr_q)) && in_valid[i]) begin
                    grant[i] = 1'b1;
                    rr_found = 1'b1;
                end
            end
        end
    end

    // Encode the one-hot grant into an index and pick the matching data word.
    always_comb begin
        grant_idx  = '0;
        grant_data = '0;
        for (int i = 0; i < NUM_IN; i++) begin
            if (grant[i]) begin
                grant_idx  = SEL_W'(i);
                grant_data = in_data[i*WIDTH +: WIDTH];
            end
        end
    end

    // Ready is gated by reset so producers see no acceptance while the
    // stage is held in reset, independent of the register contents.
    assign in_ready = (rst_n && load_en) ? grant : '0;

    // A grant always implies the channel is valid, so any ready bit means
    // a transfer happens at the next edge.
    assign xfer = |in_ready;

    // Next-state for the output register. A transfer overwrites the held
    // word (covering the drain-and-load case without a bubble); a drain with
    // no transfer only clears valid and leaves data/sel at their last value.
    always_comb begin
        out_data_d  = out_data_q;
        out_sel_d   = out_sel_q;
        out_valid_d = out_valid_q;
        if (xfer) begin
            out_data_d  = grant_data;
            out_sel_d   = grant_idx;
            out_valid_d = 1'b1;
        end else if (out_valid_q && out_ready) begin
            out_valid_d = 1'b0;
        end
    end

    // The pointer only moves on a round-robin transfer, and then to the
    // channel just after the winner, wrapping from the top channel to 0.
    always_comb begin
        ptr_d = ptr_q;
        if (!mode && xfer) begin
            if (grant_idx == SEL_W'(NUM_IN - 1)) begin
                ptr_d = '0;
            end else begin
                ptr_d = grant_idx + SEL_W'(1);
            end
        end
    end

    // State registers with asynchronous reset; reset discards any held word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_data_q  <= '0;
            out_sel_q   <= '0;
            out_valid_q <= 1'b0;
            ptr_q       <= '0;
        end else begin
            out_data_q  <= out_data_d;
            out_sel_q   <= out_sel_d;
            out_valid_q <= out_valid_d;
            ptr_q       <= ptr_d;
        end
    end

    assign out_data  = out_data_q;
    assign out_sel   = out_sel_q;
    assign out_valid = out_valid_q;

`ifdef RR_MUX_STAT_EN
    // Drain statistics: count words the consumer accepted, saturating at the
    // all-ones value so a long run never wraps back to a small number.
    logic [31:0] xfer_cnt_q, xfer_cnt_d;

    always_comb begin
        xfer_cnt_d = xfer_cnt_q;
        if (out_valid_q && out_ready && (xfer_cnt_q != 32'hFFFF_FFFF)) begin
            xfer_cnt_d = xfer_cnt_q + 32'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            xfer_cnt_q <= 32'd0;
        end else begin
            xfer_cnt_q <= xfer_cnt_d;
        end
    end

    assign xfer_cnt = xfer_cnt_q;
`else
    assign xfer_cnt = 32'd0;
`endif

endmodule

// File: tb/tb_rr_mux_stage.sv
// ---------------------------------------------------------------------------
// tb_rr_mux_stage
//
// Self-checking bench for rr_mux_stage (NUM_IN = 4, WIDTH = 32).
// The stimulus process issues directed per-cycle vectors and pushes the
// hand-computed word expected from each transfer into a queue. A separate
// monitor pops and compares whenever the DUT drains a word
// (out_valid & out_ready). Reset state, ready vectors, hold behaviour and
// the statistics counter are compared directly by the stimulus process.
// ---------------------------------------------------------------------------
module tb_rr_mux_stage;

   localparam int WIDTH  = 32;
   localparam int NUM_IN = 4;
   localparam int SEL_W  = 2;

   typedef struct packed {
      logic [31:0] data;
      logic [1:0]  sel;
   } exp_t;

   logic                    clk;
   logic                    rst_n;
   logic                    mode;
   logic [SEL_W-1:0]        sel;
   logic [NUM_IN*WIDTH-1:0] in_data;
   logic [NUM_IN-1:0]       in_valid;
   logic [NUM_IN-1:0]       in_ready;
   logic [WIDTH-1:0]        out_data;
   logic [SEL_W-1:0]        out_sel;
   logic                    out_valid;
   logic                    out_ready;
   logic [31:0]             xfer_cnt;

   exp_t expQ[$];
   int   checks     = 0;
   int   errors     = 0;
   int   drainCount = 0;

   rr_mux_stage #(
      .WIDTH  (WIDTH),
      .NUM_IN (NUM_IN),
      .SEL_W  (SEL_W)
   ) dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .mode      (mode),
      .sel       (sel),
      .in_data   (in_data),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .out_data  (out_data),
      .out_sel   (out_sel),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .xfer_cnt  (xfer_cnt)
   );

   // Free-running 10-unit clock
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   // Single comparison point shared by all direct checks
   task automatic checkOutput(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h", name, actual, expected);
      end
   endtask

   task automatic setData(input logic [31:0] d0, input logic [31:0] d1,
                          input logic [31:0] d2, input logic [31:0] d3);
      in_data = {d3, d2, d1, d0};
   endtask

   // One cycle of stimulus: drive controls, check the combinational ready
   // vector, optionally queue the expected transferred word, then advance
   // to just after the next rising edge.
   task automatic applyStimulus(input string tag, input logic m,
                                input logic [1:0] s, input logic [3:0] v,
                                input logic r, input logic [3:0] expReady,
                                input logic doPush, input logic [31:0] eData,
                                input logic [1:0] eSel);
      exp_t e;
      mode      = m;
      sel       = s;
      in_valid  = v;
      out_ready = r;
      if (doPush) begin
         e.data = eData;
         e.sel  = eSel;
         expQ.push_back(e);
      end
      #1;
      checkOutput({tag, " in_ready"}, 32'(in_ready), 32'(expReady));
      @(posedge clk);
      #1;
   endtask

   // Monitor: every drained word must match the head of the scoreboard
   initial begin
      exp_t e;
      forever begin
         @(negedge clk);
         if (rst_n && out_valid && out_ready) begin
            if (expQ.size() == 0) begin
               checks++;
               errors++;
               $display("[TB] FAIL drain unexpected: got data %h sel %0d expected no word",
                        out_data, out_sel);
            end else begin
               e = expQ.pop_front();
               checkOutput("drain data", out_data, e.data);
               checkOutput("drain sel", 32'(out_sel), 32'(e.sel));
               drainCount++;
            end
         end
      end
   end

   initial begin
      rst_n     = 1'b0;
      mode      = 1'b0;
      sel       = '0;
      in_valid  = 4'hF;
      out_ready = 1'b1;
      setData(32'h10, 32'h11, 32'h12, 32'h13);

      // Reset state, with inputs valid to show ready is suppressed
      #1;
      checkOutput("reset out_valid", 32'(out_valid), 32'd0);
      checkOutput("reset out_data", out_data, 32'd0);
      checkOutput("reset out_sel", 32'(out_sel), 32'd0);
      checkOutput("reset in_ready", 32'(in_ready), 32'd0);
      checkOutput("reset xfer_cnt", xfer_cnt, 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;

      // Fixed select: sel picks the channel, others never see ready
      $display("[TB] fixed-select mode");
      setData(32'hAAAAAAAA, 32'h55555555, 32'h22222222, 32'h33333333);
      applyStimulus("fix sel0", 1'b1, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'hAAAAAAAA, 2'd0);
      checkOutput("fix sel0 out_data", out_data, 32'hAAAAAAAA);
      checkOutput("fix sel0 out_valid", 32'(out_valid), 32'd1);
      applyStimulus("fix sel1", 1'b1, 2'd1, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'h55555555, 2'd1);
      checkOutput("fix sel1 out_data", out_data, 32'h55555555);
      checkOutput("fix sel1 out_sel", 32'(out_sel), 32'd1);
      applyStimulus("fix sel1 invalid", 1'b1, 2'd1, 4'b1101, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0);
      checkOutput("drain out_valid", 32'(out_valid), 32'd0);
      checkOutput("drain hold data", out_data, 32'h55555555);
      checkOutput("drain hold sel", 32'(out_sel), 32'd1);
      applyStimulus("fix sel2", 1'b1, 2'd2, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'h22222222, 2'd2);
      applyStimulus("fix idle", 1'b1, 2'd2, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0);

      // Round-robin, all channels valid: pointer still at 0
      $display("[TB] round-robin all valid");
      setData(32'h10, 32'h11, 32'h12, 32'h13);
      applyStimulus("rr all 0", 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h10, 2'd0);
      applyStimulus("rr all 1", 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0010, 1'b1, 32'h11, 2'd1);
      applyStimulus("rr all 2", 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0100, 1'b1, 32'h12, 2'd2);
      applyStimulus("rr all 3", 1'b0, 2'd0, 4'b1111, 1'b1, 4'b1000, 1'b1, 32'h13, 2'd3);
      applyStimulus("rr all 4", 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h10, 2'd0);

      // Round-robin, channels 1 and 3: grant 3 at ptr 2 wraps back to 1
      $display("[TB] round-robin sparse");
      applyStimulus("rr sparse 0", 1'b0, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 32'h11, 2'd1);
      applyStimulus("rr sparse 1", 1'b0, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 32'h13, 2'd3);
      applyStimulus("rr sparse 2", 1'b0, 2'd0, 4'b1010, 1'b1, 4'b0010, 1'b1, 32'h11, 2'd1);
      applyStimulus("rr sparse 3", 1'b0, 2'd0, 4'b1010, 1'b1, 4'b1000, 1'b1, 32'h13, 2'd3);
      applyStimulus("rr none", 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0);
      checkOutput("no valid out_valid", 32'(out_valid), 32'd0);

      // Backpressure: held word stays put, then reload with no bubble
      $display("[TB] backpressure");
      setData(32'h12345678, 32'h11, 32'h87654321, 32'h13);
      applyStimulus("bp load", 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 32'h12345678, 2'd0);
      for (int c = 0; c < 3; c++) begin
         applyStimulus("bp stall", 1'b0, 2'd0, 4'b0100, 1'b0, 4'b0000, 1'b0, 32'h0, 2'd0);
         checkOutput("bp hold data", out_data, 32'h12345678);
         checkOutput("bp hold valid", 32'(out_valid), 32'd1);
      end
      applyStimulus("bp reload", 1'b0, 2'd0, 4'b0100, 1'b1, 4'b0100, 1'b1, 32'h87654321, 2'd2);
      checkOutput("bp reload data", out_data, 32'h87654321);
      checkOutput("bp reload sel", 32'(out_sel), 32'd2);
      applyStimulus("bp drain", 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0);

      // Reset mid-stream: hold a word from channel 1 (ptr moves to 2), reset
      $display("[TB] reset mid-stream");
      setData(32'h10, 32'h11, 32'h12, 32'h13);
      applyStimulus("rst load", 1'b0, 2'd0, 4'b0010, 1'b0, 4'b0010, 1'b1, 32'h11, 2'd1);
      applyStimulus("rst hold", 1'b0, 2'd0, 4'b0000, 1'b0, 4'b0000, 1'b0, 32'h0, 2'd0);
      checkOutput("rst pre out_valid", 32'(out_valid), 32'd1);
      checkOutput("rst pre out_data", out_data, 32'h11);
      rst_n     = 1'b0;
      in_valid  = 4'hF;
      out_ready = 1'b1;
      expQ.delete();
      drainCount = 0;
      #1;
      checkOutput("rst mid out_valid", 32'(out_valid), 32'd0);
      checkOutput("rst mid out_data", out_data, 32'd0);
      checkOutput("rst mid in_ready", 32'(in_ready), 32'd0);
      @(posedge clk);
      #1;
      rst_n = 1'b1;
      applyStimulus("post rst", 1'b0, 2'd0, 4'b1111, 1'b1, 4'b0001, 1'b1, 32'h10, 2'd0);
      checkOutput("post rst out_sel", 32'(out_sel), 32'd0);
      applyStimulus("post rst drain", 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0);
      applyStimulus("post rst idle", 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0);

`ifdef RR_MUX_STAT_EN
      checkOutput("xfer_cnt count", xfer_cnt, 32'(drainCount));
      force dut.xfer_cnt_q = 32'hFFFFFFFE;
      #1;
      release dut.xfer_cnt_q;
      for (int c = 0; c < 3; c++) begin
         applyStimulus("sat load", 1'b0, 2'd0, 4'b0001, 1'b1, 4'b0001, 1'b1, 32'h10, 2'd0);
      end
      applyStimulus("sat drain", 1'b0, 2'd0, 4'b0000, 1'b1, 4'b0000, 1'b0, 32'h0, 2'd0);
      checkOutput("xfer_cnt saturate", xfer_cnt, 32'hFFFFFFFF);
`else
      checkOutput("xfer_cnt tied", xfer_cnt, 32'd0);
`endif

      checkOutput("scoreboard empty", 32'(expQ.size()), 32'd0);
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rr_mux_stage.md
Name: rr_mux_stage

Overview:
- Parametrised N-input, WIDTH-bit multiplexer with valid/ready handshakes on every input and a registered one-entry output stage.
- Successor to the combinational 2:1 datapath mux, for datapath sources that can stall.
- Two modes: round-robin arbitration across all inputs, or fixed selection by an index input (legacy mux behaviour).
- Sits between producers (register file and ALU result paths) and a single downstream consumer.

Parameters:
- WIDTH, 32, data width per channel in bits.
- NUM_IN, 4, number of input channels (2..16).
- SEL_W, $clog2(NUM_IN), width of the channel index.

Ports:
- clk  input  1  rising-edge clock.
- rst_n  input  1  asynchronous active-low reset.
- mode  input  1  0 = round-robin, 1 = fixed select.
- sel  input  SEL_W  channel index used when mode=1.
- in_data  input  NUM_IN*WIDTH  channel i occupies bits [i*WIDTH +: WIDTH].
- in_valid  input  NUM_IN  per-channel valid.
- in_ready  output  NUM_IN  per-channel ready (combinational).
- out_data  output  WIDTH  registered data.
- out_sel  output  SEL_W  index of the channel that produced out_data.
- out_valid  output  1  output register holds a word.
- out_ready  input  1  consumer accepts this cycle.
- xfer_cnt  output  32  accepted-transfer count (see Optional Feature).

Behaviour:
Reset
- Asynchronous on rst_n low: out_valid=0, out_data=0, out_sel=0, rr pointer ptr=0, xfer_cnt=0.
- in_ready is forced to all-zero while rst_n is low.

Load rule
- load_en = !out_valid | out_ready.
- A transfer on channel i occurs when in_valid[i] & in_ready[i].
- in_ready[i] = load_en & grant[i]. At most one grant bit is set per cycle.

Grant, mode 0 (round-robin)
- Grant goes to the first channel with in_valid set, scanning ptr, ptr+1, …, NUM_IN-1, then 0 upward.
- After a transfer from channel k: ptr <= (k+1) mod NUM_IN.
- ptr is unchanged when no transfer occurs.

Grant, mode 1 (fixed)
- grant[sel] = in_valid[sel]; all other grants are 0.
- sel >= NUM_IN grants nothing.
- ptr is unchanged in this mode.

Timing
- A transfer loads out_data = in_data[k], out_sel = k, out_valid = 1 at the same edge.
- Latency is 1 cycle from input transfer to output visible.

Output drain
- out_valid & out_ready with no new transfer: out_valid <= 0; out_data and out_sel hold their last value.
- Simultaneous drain and load: the new word replaces the old in the same cycle. No bubble; full throughput is 1 word/cycle.
- out_valid & !out_ready: out_data and out_sel are stable and all in_ready are 0 (backpressure).

Mode and select changes
- A change of mode or sel takes effect on the grant in the same cycle.
- A word already held in the output register is unaffected.

Boundaries
- No valid inputs: no transfer.
- Reset asserted mid-transfer discards the held word.
- ptr wrap from NUM_IN-1 to 0 is required for non-power-of-2 NUM_IN (e.g. 3).

Optional Feature:
- Macro: RR_MUX_STAT_EN.
- Defined: xfer_cnt increments by 1 on each output drain (out_valid & out_ready). It saturates at 32'hFFFFFFFF and resets to 0.
- Undefined: xfer_cnt is tied to 0 and no counter logic is generated. The port list is identical in both builds.

Test Plan:
- Mode 1, NUM_IN=4, sel=0, in0=32'hAAAAAAAA, in1=32'h55555555, all valid, out_ready=1 -> next cycle out_data=AAAAAAAA, out_sel=0. Then sel=1 -> out_data=55555555, out_sel=1. in_ready[2..3] stay 0 throughout.
- Mode 0, all four channels valid continuously (data 32'h10+i), out_ready=1 -> out_sel sequence 0,1,2,3,0,… at one word per cycle.
- Mode 0, only channels 1 and 3 valid -> out_sel alternates 1,3,1,3. With ptr=2, a grant to 3 is followed by wrap to 1.
- Backpressure: out_ready=0 for 3 cycles with word 32'h12345678 held -> out_data stable, in_ready all 0. Then out_ready=1 with channel 2 valid at 32'h87654321 -> the next edge loads it with no bubble.
- Reset mid-stream: rst_n low while out_valid=1 -> immediate out_valid=0, out_data=0, in_ready=0. After release, mode 0 grants channel 0 first.
- With RR_MUX_STAT_EN: 5 drains -> xfer_cnt=5. Preload near saturation (force) -> counter holds at FFFFFFFF. Without the macro -> xfer_cnt=0 always.
